dmem_responder: RTL and testbench

Data-memory responder for the single-cycle MIPS processor: the slave end of the processor's `address_dmem`/`data`/`wren`/`q_dmem` port. It services word loads and stores against an internal RAM and a small memory-mapped I/O page. The MMIO page holds a free-running cycle counter, a scratch register, and an 8-entry output FIFO that is drained by an external consumer over a valid/ready handshake. It sits beside the processor in the top level, in place of the behavioural dmem used in simulation.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - processor data-memory slave: word RAM plus optional MMIO page
// MMIO page (cycle counter, scratch, status, output FIFO) is built only when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);
    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [12:0] RAM_LIMIT = 13'(RAM_WORDS);

    logic [31:0]   r_mem [RAM_WORDS];
    logic [31:0]   r_q;
    logic          w_ram_sel;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_rd_data;

    assign w_ram_sel = {1'b0, address_dmem} < RAM_LIMIT;
    assign w_ram_idx = address_dmem[AW-1:0];
    assign q_dmem    = r_q;

    // RAM has no reset; the combinational read below sees the pre-edge word, giving read-first behaviour
    always_ff @(posedge clock) begin
        if (wren && w_ram_sel) begin
            r_mem[w_ram_idx] <= data;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [11:0] ADDR_CNT   = 12'hFF0;
    localparam logic [11:0] ADDR_FIFO  = 12'hFF4;
    localparam logic [11:0] ADDR_STAT  = 12'hFF8;
    localparam logic [11:0] ADDR_SCR   = 12'hFFC;
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   r_cnt;
    logic [31:0]   r_scratch;
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic          w_sel_cnt;
    logic          w_sel_fifo;
    logic          w_sel_stat;
    logic          w_sel_scr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic [31:0]   w_status;

    assign w_sel_cnt  = (address_dmem == ADDR_CNT);
    assign w_sel_fifo = (address_dmem == ADDR_FIFO);
    assign w_sel_stat = (address_dmem == ADDR_STAT);
    assign w_sel_scr  = (address_dmem == ADDR_SCR);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_pop      = !w_empty && out_ready;
    assign w_push_req = wren && w_sel_fifo;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_status   = {24'd0, 4'(r_count), 1'b0, r_overflow, w_full, w_empty};
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 32'd0 : r_fifo[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_scratch <= '0;
        end else begin
            if (wren && w_sel_cnt) begin
                r_cnt <= data;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (wren && w_sel_scr) begin
                r_scratch <= data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW+1)'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end else if (wren && w_sel_stat) begin
                r_overflow <= 1'b0;
            end
        end
    end
`else
    logic w_unused_ready;

    assign w_unused_ready = out_ready;
    assign out_valid      = 1'b0;
    assign out_data       = 32'd0;
`endif

    always_comb begin
        w_rd_data = 32'd0;
        if (w_ram_sel) begin
            w_rd_data = r_mem[w_ram_idx];
`ifdef DMEM_MMIO_EN
        end else if (w_sel_cnt) begin
            w_rd_data = r_cnt;
        end else if (w_sel_fifo) begin
            w_rd_data = out_data;
        end else if (w_sel_stat) begin
            w_rd_data = w_status;
        end else if (w_sel_scr) begin
            w_rd_data = r_scratch;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a queue/array reference model
module tb_dmem_responder;
    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    always #5 clock = ~clock;

    dmem_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .address_dmem(address_dmem),
        .data(data),
        .wren(wren),
        .q_dmem(q_dmem),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] q;
        bit          q_care;
        logic        ov;
        logic [31:0] od;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    int unsigned cyc = 0;

    logic [31:0] m_ram [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [31:0] m_cnt;
    logic [31:0] m_scr;
    logic [31:0] m_fifo[$];
    bit          m_ovf;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, output bit care);
        int sz;
        care = 1'b1;
        sz = m_fifo.size();
        if (int'(a) < RAM_WORDS) begin
            care = m_known[int'(a)];
            return m_ram[int'(a)];
        end
        if (MMIO) begin
            if (a == 12'hFF0) return m_cnt;
            if (a == 12'hFF4) return (sz > 0) ? m_fifo[0] : 32'd0;
            if (a == 12'hFF8)
                return 32'(sz * 16 + (m_ovf ? 4 : 0) + (sz == FIFO_DEPTH ? 2 : 0) + (sz == 0 ? 1 : 0));
            if (a == 12'hFFC) return m_scr;
        end
        return 32'd0;
    endfunction

    // one clock of stimulus: model computes this access's result and the post-edge FIFO head
    task automatic cycle(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
        exp_t e;
        bit   care;
        bit   pop;
        bit   full;
        logic [31:0] rv;
        address_dmem = a;
        data         = d;
        wren         = we;
        out_ready    = rdy;
        rv = model_read(a, care);
        if (int'(a) < RAM_WORDS && we) begin
            m_ram[int'(a)]   = d;
            m_known[int'(a)] = 1'b1;
        end
        if (MMIO) begin
            pop  = (m_fifo.size() > 0) && rdy;
            full = (m_fifo.size() == FIFO_DEPTH);
            if (pop) void'(m_fifo.pop_front());
            if (we && a == 12'hFF4) begin
                if (!full || pop) m_fifo.push_back(d);
                else m_ovf = 1'b1;
            end
            if (we && a == 12'hFF8) m_ovf = 1'b0;
            m_cnt = (we && a == 12'hFF0) ? d : m_cnt + 32'd1;
            if (we && a == 12'hFFC) m_scr = d;
        end
        e.due    = cyc + 1;
        e.q      = rv;
        e.q_care = care;
        e.ov     = (m_fifo.size() > 0);
        e.od     = e.ov ? m_fifo[0] : 32'd0;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset q_dmem", q_dmem, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_data", out_data, 32'd0);
        exp_q.delete();
        m_cnt = '0;
        m_scr = '0;
        m_fifo.delete();
        m_ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clock) begin
        if (reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.q_care) check("q_dmem", q_dmem, mon_e.q);
            check("out_valid", {31'd0, out_valid}, {31'd0, mon_e.ov});
            check("out_data", out_data, mon_e.od);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ra;
        do_reset();

        cycle(12'h011, 32'h1234_5678, 1'b1, 1'b0);
        cycle(12'h010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cycle(12'h010, 32'h0, 1'b0, 1'b0);
        cycle(12'h011, 32'h0, 1'b0, 1'b0);
        cycle(12'h020, 32'h1, 1'b1, 1'b0);
        cycle(12'h020, 32'h5, 1'b1, 1'b0);
        cycle(12'h020, 32'h0, 1'b0, 1'b0);
        cycle(12'(RAM_WORDS - 1), 32'hCAFE_F00D, 1'b1, 1'b0);
        cycle(12'(RAM_WORDS - 1), 32'h0, 1'b0, 1'b0);
        cycle(12'(RAM_WORDS), 32'h7777_7777, 1'b1, 1'b0);
        cycle(12'(RAM_WORDS), 32'h0, 1'b0, 1'b0);

        for (int i = 1; i <= 9; i++) cycle(12'hFF4, 32'(i), 1'b1, 1'b0);
        cycle(12'hFF8, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF4, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF8, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle(12'hFF8, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF4, 32'hAA, 1'b1, 1'b1);
        cycle(12'hFF8, 32'h0, 1'b0, 1'b0);
        repeat (10) cycle(12'h000, 32'h0, 1'b0, 1'b1);
        cycle(12'hFF8, 32'h0, 1'b0, 1'b0);

        cycle(12'hFF0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cycle(12'h000, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF0, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF0, 32'h0, 1'b0, 1'b0);
        cycle(12'hFFC, 32'h1234_ABCD, 1'b1, 1'b0);
        cycle(12'hFFC, 32'h0, 1'b0, 1'b0);
        cycle(12'hFF1, 32'h5555_5555, 1'b1, 1'b0);
        cycle(12'hFF1, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) cycle(12'hFF4, 32'h100 + 32'(i), 1'b1, 1'b0);
        cycle(12'h010, 32'h0, 1'b0, 1'b0);
        do_reset();
        cycle(12'hFF8, 32'h0, 1'b0, 1'b0);
        cycle(12'h010, 32'h0, 1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3: ra = 12'($urandom_range(0, 15));
                4:          ra = 12'(RAM_WORDS - 1);
                5:          ra = 12'(RAM_WORDS);
                6:          ra = 12'hFF0;
                7, 8:       ra = 12'hFF4;
                9:          ra = 12'hFF8;
                10:         ra = 12'hFFC;
                default:    ra = ($urandom_range(0, 1) == 0) ? 12'hFF1 : 12'hFFE;
            endcase
            cycle(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
            if (n == 1500) do_reset();
        end

        @(negedge clock);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
